// File: rtl/sy_ppl_alu_iq.sv
// sy_ppl_alu_iq: ALU issue queue with wakeup tracking and oldest-ready select
// Ports: clk_i/rst_i (async, active-low); flush_i discards the queue and the issue register.
//   dsp_*: dispatch of one op per cycle when dsp_rdy_o; awk_*: wakeup broadcast ports.
//   iss_*: registered issue interface (valid/ready); iq_empty_o: no valid entries.
module sy_ppl_alu_iq #(
   parameter int DEPTH       = 8,
   parameter int ROB_WTH     = 6,
   parameter int PHY_REG_WTH = 7,
   parameter int PLD_WTH     = 256,
   parameter int AWK_NUM     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           dsp_vld_i,
   output logic                           dsp_rdy_o,
   input  logic [ROB_WTH-1:0]             dsp_rob_idx_i,
   input  logic [PLD_WTH-1:0]             dsp_pld_i,
   input  logic [PHY_REG_WTH-1:0]         dsp_rs1_idx_i,
   input  logic [PHY_REG_WTH-1:0]         dsp_rs2_idx_i,
   input  logic                           dsp_rs1_rdy_i,
   input  logic                           dsp_rs2_rdy_i,
   input  logic                           dsp_rdst_en_i,
   input  logic [PHY_REG_WTH-1:0]         dsp_rdst_idx_i,
   input  logic [AWK_NUM-1:0]             awk_vld_i,
   input  logic [AWK_NUM*PHY_REG_WTH-1:0] awk_idx_i,
   output logic                           iss_vld_o,
   input  logic                           iss_rdy_i,
   output logic [ROB_WTH-1:0]             iss_rob_idx_o,
   output logic [PLD_WTH-1:0]             iss_pld_o,
   output logic [PHY_REG_WTH-1:0]         iss_rs1_idx_o,
   output logic [PHY_REG_WTH-1:0]         iss_rs2_idx_o,
   output logic                           iss_rdst_en_o,
   output logic [PHY_REG_WTH-1:0]         iss_rdst_idx_o,
   output logic                           iq_empty_o
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW+1)'(DEPTH);
   logic [DEPTH-1:0] vld, rs1_rdy, rs2_rdy, cand, win, wk1, wk2;
   logic [DEPTH-1:0][DEPTH-1:0] age;
   logic [ROB_WTH-1:0] rob [DEPTH];
   logic [PLD_WTH-1:0] pld [DEPTH];
   logic [PHY_REG_WTH-1:0] rs1_idx [DEPTH];
   logic [PHY_REG_WTH-1:0] rs2_idx [DEPTH];
   logic [PHY_REG_WTH-1:0] rdst_idx [DEPTH];
   logic [DEPTH-1:0] rdst_en;
   logic [IW:0] cnt;
   logic [IW-1:0] free_idx, win_idx;
   logic accept, dsp_fire, sel_fire, dwk1, dwk2;
   // accept excludes rst_i so the reset net never feeds synchronous data paths
   assign accept = (cnt < FULL) && !flush_i;
   assign dsp_rdy_o = rst_i && accept;
   assign dsp_fire = dsp_vld_i && accept;
   assign cand = vld & rs1_rdy & rs2_rdy;
   assign sel_fire = (|cand) && (!iss_vld_o || iss_rdy_i);
   assign iq_empty_o = (cnt == '0);
   always_comb begin
      wk1 = '0;
      wk2 = '0;
      dwk1 = 1'b0;
      dwk2 = 1'b0;
      for (int p = 0; p < AWK_NUM; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = wk1[i] | (vld[i] && awk_vld_i[p] && awk_idx_i[p*PHY_REG_WTH +: PHY_REG_WTH] == rs1_idx[i]);
            wk2[i] = wk2[i] | (vld[i] && awk_vld_i[p] && awk_idx_i[p*PHY_REG_WTH +: PHY_REG_WTH] == rs2_idx[i]);
         end
         dwk1 = dwk1 | (awk_vld_i[p] && awk_idx_i[p*PHY_REG_WTH +: PHY_REG_WTH] == dsp_rs1_idx_i);
         dwk2 = dwk2 | (awk_vld_i[p] && awk_idx_i[p*PHY_REG_WTH +: PHY_REG_WTH] == dsp_rs2_idx_i);
      end
   end
   // a candidate wins unless some other candidate is older than it
   always_comb begin
      win = cand;
      win_idx = '0;
      free_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         for (int j = 0; j < DEPTH; j++)
            if (cand[j] && age[j][i]) win[i] = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (win[i]) win_idx = IW'(i);
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!vld[i]) free_idx = IW'(i);
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         vld <= '0;
         rs1_rdy <= '0;
         rs2_rdy <= '0;
         age <= '0;
         cnt <= '0;
         iss_vld_o <= 1'b0;
         iss_rob_idx_o <= '0;
         iss_pld_o <= '0;
         iss_rs1_idx_o <= '0;
         iss_rs2_idx_o <= '0;
         iss_rdst_en_o <= 1'b0;
         iss_rdst_idx_o <= '0;
      end else begin
         rs1_rdy <= rs1_rdy | wk1;
         rs2_rdy <= rs2_rdy | wk2;
         if (dsp_fire) begin
            rs1_rdy[free_idx] <= dsp_rs1_rdy_i | dwk1;
            rs2_rdy[free_idx] <= dsp_rs2_rdy_i | dwk2;
            age[free_idx] <= '0;
            for (int j = 0; j < DEPTH; j++)
               if (vld[j]) age[j][free_idx] <= 1'b1;
         end
         if (flush_i) begin
            vld <= '0;
            cnt <= '0;
            iss_vld_o <= 1'b0;
         end else begin
            vld <= (vld & ~(win & {DEPTH{sel_fire}})) | (DEPTH'(dsp_fire) << free_idx);
            cnt <= cnt + {{IW{1'b0}}, dsp_fire} - {{IW{1'b0}}, sel_fire};
            iss_vld_o <= sel_fire ? 1'b1 : (iss_rdy_i ? 1'b0 : iss_vld_o);
            if (sel_fire) begin
               iss_rob_idx_o <= rob[win_idx];
               iss_pld_o <= pld[win_idx];
               iss_rs1_idx_o <= rs1_idx[win_idx];
               iss_rs2_idx_o <= rs2_idx[win_idx];
               iss_rdst_en_o <= rdst_en[win_idx];
               iss_rdst_idx_o <= rdst_idx[win_idx];
            end
         end
      end
   end
   // payload storage needs no reset: it is only read behind a valid bit
   always_ff @(posedge clk_i) begin
      if (dsp_fire) begin
         rob[free_idx] <= dsp_rob_idx_i;
         pld[free_idx] <= dsp_pld_i;
         rs1_idx[free_idx] <= dsp_rs1_idx_i;
         rs2_idx[free_idx] <= dsp_rs2_idx_i;
         rdst_en[free_idx] <= dsp_rdst_en_i;
         rdst_idx[free_idx] <= dsp_rdst_idx_i;
      end
   end
endmodule

// File: tb/tb_sy_ppl_alu_iq.sv
// tb_sy_ppl_alu_iq: randomized scoreboard bench for sy_ppl_alu_iq against an age-ordered list model
module tb_sy_ppl_alu_iq;
   localparam int D = 8, RW = 6, PW = 7, LW = 256, AN = 2;
   typedef struct packed {
      logic [RW-1:0] rob;
      logic [LW-1:0] pld;
      logic [PW-1:0] rs1;
      logic [PW-1:0] rs2;
      logic          den;
      logic [PW-1:0] dst;
   } op_t;
   typedef struct packed {
      op_t  op;
      logic r1;
      logic r2;
   } ent_t;
   logic clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0, dsp_vld_i = 1'b0, iss_rdy_i = 1'b0;
   logic [AN-1:0] awk_vld = '0;
   logic [AN*PW-1:0] awk_idx = '0;
   ent_t din = '0;
   logic dsp_rdy_o, iss_vld_o, iss_rdst_en_o, iq_empty_o;
   logic [RW-1:0] iss_rob_idx_o;
   logic [LW-1:0] iss_pld_o;
   logic [PW-1:0] iss_rs1_idx_o, iss_rs2_idx_o, iss_rdst_idx_o;
   ent_t mq[$];
   op_t exp_q[$];
   op_t m_out = '0, mon_a, mon_e;
   logic m_vld = 1'b0;
   int total = 0, bad = 0, seq = 0;
   always #5 clk_i = ~clk_i;
   sy_ppl_alu_iq #(.DEPTH(D), .ROB_WTH(RW), .PHY_REG_WTH(PW), .PLD_WTH(LW), .AWK_NUM(AN)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .dsp_vld_i(dsp_vld_i), .dsp_rdy_o(dsp_rdy_o), .dsp_rob_idx_i(din.op.rob), .dsp_pld_i(din.op.pld),
      .dsp_rs1_idx_i(din.op.rs1), .dsp_rs2_idx_i(din.op.rs2), .dsp_rs1_rdy_i(din.r1), .dsp_rs2_rdy_i(din.r2),
      .dsp_rdst_en_i(din.op.den), .dsp_rdst_idx_i(din.op.dst),
      .awk_vld_i(awk_vld), .awk_idx_i(awk_idx),
      .iss_vld_o(iss_vld_o), .iss_rdy_i(iss_rdy_i), .iss_rob_idx_o(iss_rob_idx_o), .iss_pld_o(iss_pld_o),
      .iss_rs1_idx_o(iss_rs1_idx_o), .iss_rs2_idx_o(iss_rs2_idx_o), .iss_rdst_en_o(iss_rdst_en_o),
      .iss_rdst_idx_o(iss_rdst_idx_o), .iq_empty_o(iq_empty_o)
   );
   function automatic logic hit(input logic [PW-1:0] r, input logic [AN-1:0] v, input logic [AN*PW-1:0] ix);
      hit = 1'b0;
      for (int p = 0; p < AN; p++)
         if (v[p] && ix[p*PW +: PW] == r) hit = 1'b1;
   endfunction
   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0b want=%0b at %0t", nm, act, exp, $time);
      end
   endtask
   // scoreboard monitor: every DUT transfer must match the next expected op
   always @(negedge clk_i) begin
      #2;
      if (rst_i && iss_vld_o && iss_rdy_i) begin
         mon_a = {iss_rob_idx_o, iss_pld_o, iss_rs1_idx_o, iss_rs2_idx_o, iss_rdst_en_o, iss_rdst_idx_o};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL issue unexpected rob=%0h rs1=%0h at %0t", mon_a.rob, mon_a.rs1, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e) begin
               bad++;
               $display("FAIL issue got rob=%0h rs1=%0h rs2=%0h dst=%0h want rob=%0h rs1=%0h rs2=%0h dst=%0h at %0t",
                        mon_a.rob, mon_a.rs1, mon_a.rs2, mon_a.dst, mon_e.rob, mon_e.rs1, mon_e.rs2, mon_e.dst, $time);
            end
         end
      end
   end
   // one clock of stimulus; the model advances from its start-of-cycle state
   task automatic cycle(input int p_dv, input int p_ird, input int p_rdy, input int p_fl, input int p_awk);
      int sel;
      logic rdy;
      ent_t e;
      @(negedge clk_i);
      chk("iss_vld", iss_vld_o, m_vld);
      chk("iq_empty", iq_empty_o, mq.size() == 0);
      dsp_vld_i = $urandom_range(99) < p_dv;
      din.op.rob = RW'(seq);
      seq++;
      din.op.pld = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      din.op.rs1 = PW'($urandom_range(15));
      din.op.rs2 = PW'($urandom_range(15));
      din.op.den = 1'($urandom_range(1));
      din.op.dst = PW'($urandom_range(127));
      din.r1 = $urandom_range(99) < p_rdy;
      din.r2 = $urandom_range(99) < p_rdy;
      iss_rdy_i = $urandom_range(99) < p_ird;
      flush_i = $urandom_range(999) < p_fl;
      for (int p = 0; p < AN; p++) begin
         awk_vld[p] = $urandom_range(99) < p_awk;
         awk_idx[p*PW +: PW] = PW'($urandom_range(15));
      end
      #1;
      rdy = (mq.size() < D) && !flush_i;
      chk("dsp_rdy", dsp_rdy_o, rdy);
      sel = -1;
      if (!m_vld || iss_rdy_i)
         foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      if (m_vld && iss_rdy_i) exp_q.push_back(m_out);
      if (flush_i) begin
         mq.delete();
         m_vld = 1'b0;
      end else begin
         if (sel >= 0) begin
            m_out = mq[sel].op;
            m_vld = 1'b1;
            mq.delete(sel);
         end else if (iss_rdy_i) m_vld = 1'b0;
         foreach (mq[i]) begin
            mq[i].r1 = mq[i].r1 | hit(mq[i].op.rs1, awk_vld, awk_idx);
            mq[i].r2 = mq[i].r2 | hit(mq[i].op.rs2, awk_vld, awk_idx);
         end
         if (dsp_vld_i && rdy) begin
            e = din;
            e.r1 = e.r1 | hit(e.op.rs1, awk_vld, awk_idx);
            e.r2 = e.r2 | hit(e.op.rs2, awk_vld, awk_idx);
            mq.push_back(e);
         end
      end
   endtask
   task automatic async_rst();
      @(negedge clk_i);
      dsp_vld_i = 1'b0;
      flush_i = 1'b0;
      iss_rdy_i = 1'b0;
      awk_vld = '0;
      #3;
      rst_i = 1'b0;
      #1;
      chk("arst_iss_vld", iss_vld_o, 1'b0);
      chk("arst_empty", iq_empty_o, 1'b1);
      chk("arst_dsp_rdy", dsp_rdy_o, 1'b0);
      mq.delete();
      exp_q.delete();
      m_vld = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask
   initial begin
      #3;
      chk("rst_dsp_rdy", dsp_rdy_o, 1'b0);
      chk("rst_iss_vld", iss_vld_o, 1'b0);
      chk("rst_empty", iq_empty_o, 1'b1);
      chk("rst_iss_data", |{iss_rob_idx_o, iss_pld_o, iss_rs1_idx_o, iss_rs2_idx_o, iss_rdst_en_o, iss_rdst_idx_o}, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (12) cycle(100, 100, 100, 0, 0);
      repeat (400) cycle(60, 70, 40, 0, 30);
      repeat (300) cycle(90, 20, 70, 0, 20);
      repeat (300) cycle(70, 80, 30, 40, 40);
      async_rst();
      repeat (3) cycle(0, 100, 0, 0, 0);
      repeat (300) cycle(80, 90, 50, 10, 40);
      repeat (60) cycle(0, 100, 0, 0, 100);
      @(negedge clk_i);
      #3;
      chk("drain", exp_q.size() == 0, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
